// File: rtl/pc_pkg.sv
// Shared types and constants for the execute-stage PC redirect logic.
package pc_pkg;

    localparam int XLEN_D = 32;

    // Fetch PC multiplexer selector encoding.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_JALR   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JAL    = 2'b11
    } pc_src_t;

    // Conditional branch funct3 encodings.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_gen.sv
// Combinational branch condition evaluation: funct3 + operands -> taken.
module branch_cond_gen
    import pc_pkg::*;
#(
    parameter int XLEN = XLEN_D
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    // Select the compare selected by funct3; reserved encodings never take.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BNE:  taken = (rs1 != rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Execute-stage control-flow resolver. Computes jump/branch targets, issues
// zero-latency redirects when fetch is ready, holds a redirect while fetch is
// stalled, flags misaligned targets and counts applied redirects.
module pc_redirect_unit
    import pc_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ready,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_imm_b,
    input  logic [XLEN-1:0]  ex_imm_j,
    input  logic [XLEN-1:0]  ex_imm_i,
    output logic [1:0]       pc_source,
    output logic [XLEN-1:0]  jalr,
    output logic [XLEN-1:0]  branch,
    output logic [XLEN-1:0]  jal,
    output logic             pc_write,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } redir_state_t;

    logic              taken_s;
    logic [XLEN-1:0]   tgt_jal_s;
    logic [XLEN-1:0]   tgt_br_s;
    logic [XLEN-1:0]   jalr_sum_s;
    logic [XLEN-1:0]   tgt_jalr_s;
    pc_src_t           kind_s;
    logic [XLEN-1:0]   sel_tgt_s;
    logic              req_s;
    logic              apply_s;

    redir_state_t      state_r;
    pc_src_t           lat_src_r;
    logic [XLEN-1:0]   lat_jal_r;
    logic [XLEN-1:0]   lat_br_r;
    logic [XLEN-1:0]   lat_jalr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              flush_r;

    branch_cond_gen #(.XLEN(XLEN)) u_cond (
        .funct3 (ex_funct3),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .taken  (taken_s)
    );

    // Target adders; JALR clears bit 0 of the sum.
    always_comb begin
        tgt_jal_s  = ex_pc + ex_imm_j;
        tgt_br_s   = ex_pc + ex_imm_b;
        jalr_sum_s = ex_rs1 + ex_imm_i;
        tgt_jalr_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end

    // Classify the EX instruction with JAL > JALR > BRANCH priority.
    always_comb begin
        kind_s    = PC_PLUS4;
        sel_tgt_s = {XLEN{1'b0}};
        if (ex_is_jal) begin
            kind_s    = PC_JAL;
            sel_tgt_s = tgt_jal_s;
        end else if (ex_is_jalr) begin
            kind_s    = PC_JALR;
            sel_tgt_s = tgt_jalr_s;
        end else if (ex_is_branch && taken_s) begin
            kind_s    = PC_BRANCH;
            sel_tgt_s = tgt_br_s;
        end else begin
            kind_s    = PC_PLUS4;
            sel_tgt_s = {XLEN{1'b0}};
        end
        req_s = ex_valid && (kind_s != PC_PLUS4);
    end

    // Fetch-facing outputs: live inputs in IDLE, latched copy in PEND, quiet in reset.
    always_comb begin
        pc_source = PC_PLUS4;
        pc_write  = 1'b0;
        misalign  = 1'b0;
        apply_s   = 1'b0;
        jal       = tgt_jal_s;
        branch    = tgt_br_s;
        jalr      = tgt_jalr_s;
        if (!rst_n) begin
            pc_source = PC_PLUS4;
        end else if (state_r == ST_PEND) begin
            pc_source = lat_src_r;
            pc_write  = fetch_ready;
            apply_s   = fetch_ready;
            jal       = lat_jal_r;
            branch    = lat_br_r;
            jalr      = lat_jalr_r;
        end else begin
            pc_write = fetch_ready;
            if (req_s && sel_tgt_s[1]) begin
                misalign = 1'b1;
            end else if (req_s) begin
                pc_source = kind_s;
                apply_s   = fetch_ready;
            end else begin
                pc_source = PC_PLUS4;
            end
        end
    end

    // Redirect FSM: capture a stalled redirect and replay it once fetch is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            lat_src_r  <= PC_PLUS4;
            lat_jal_r  <= {XLEN{1'b0}};
            lat_br_r   <= {XLEN{1'b0}};
            lat_jalr_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s && !sel_tgt_s[1] && !fetch_ready) begin
                        state_r    <= ST_PEND;
                        lat_src_r  <= kind_s;
                        lat_jal_r  <= tgt_jal_s;
                        lat_br_r   <= tgt_br_s;
                        lat_jalr_r <= tgt_jalr_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (fetch_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PEND;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // One-cycle flush after each applied redirect, plus a saturating redirect count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            flush_r <= apply_s;
            if (apply_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign flush     = flush_r;
    assign redir_cnt = cnt_r;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed table, corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_pc_redirect_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm_b, ex_imm_j, ex_imm_i;
    logic [1:0]  pc_source, b_pc_source;
    logic [31:0] jalr, branch, jal, b_jalr, b_branch, b_jal;
    logic        pc_write, flush, misalign, b_pc_write, b_flush, b_misalign;
    logic [15:0] redir_cnt;
    logic [1:0]  b_redir_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_pend;
    logic [1:0]  m_src;
    logic [31:0] m_jal, m_br, m_jalr;
    int          m_cnt;
    bit          m_flush;
    // per-cycle model results
    logic [1:0]  e_kind, e_src;
    bit          e_pw, e_mis, e_apply;
    logic [31:0] e_jal, e_br, e_jalr;

    always #5 clk = ~clk;

    pc_redirect_unit #(.XLEN(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
        .pc_source(pc_source), .jalr(jalr), .branch(branch), .jal(jal),
        .pc_write(pc_write), .flush(flush), .misalign(misalign), .redir_cnt(redir_cnt)
    );

    pc_redirect_unit #(.XLEN(32), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .ex_valid(ex_valid),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm_b(ex_imm_b), .ex_imm_j(ex_imm_j), .ex_imm_i(ex_imm_i),
        .pc_source(b_pc_source), .jalr(b_jalr), .branch(b_branch), .jal(b_jal),
        .pc_write(b_pc_write), .flush(b_flush), .misalign(b_misalign), .redir_cnt(b_redir_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_cnt = 0; m_flush = 0; m_src = 2'd0;
        m_jal = 32'd0; m_br = 32'd0; m_jalr = 32'd0;
    endtask

    task automatic model_eval();
        logic [31:0] tj, tb, tr, tgt;
        tj = ex_pc + ex_imm_j;
        tb = ex_pc + ex_imm_b;
        tr = (ex_rs1 + ex_imm_i) & 32'hFFFF_FFFE;
        e_pw = fetch_ready;
        e_mis = 0;
        if (m_pend) begin
            e_src = m_src; e_apply = fetch_ready;
            e_jal = m_jal; e_br = m_br; e_jalr = m_jalr;
            e_kind = 2'd0;
        end else begin
            e_jal = tj; e_br = tb; e_jalr = tr;
            if (!ex_valid)                                         e_kind = 2'd0;
            else if (ex_is_jal)                                    e_kind = 2'd3;
            else if (ex_is_jalr)                                   e_kind = 2'd1;
            else if (ex_is_branch && br_taken(ex_funct3, ex_rs1, ex_rs2)) e_kind = 2'd2;
            else                                                   e_kind = 2'd0;
            tgt = (e_kind == 2'd3) ? tj : (e_kind == 2'd1) ? tr : tb;
            e_mis = (e_kind != 2'd0) && tgt[1];
            e_src = e_mis ? 2'd0 : e_kind;
            e_apply = (e_src != 2'd0) && fetch_ready;
        end
    endtask

    task automatic model_clock();
        m_flush = e_apply;
        if (e_apply && m_cnt < 65535) m_cnt++;
        if (m_pend) begin
            if (fetch_ready) m_pend = 0;
        end else if (e_src != 2'd0 && !fetch_ready) begin
            m_pend = 1; m_src = e_src; m_jal = e_jal; m_br = e_br; m_jalr = e_jalr;
        end
    endtask

    // Called at a negedge with inputs set; checks, clocks, returns at the next negedge.
    task automatic cycle();
        #1;
        model_eval();
        chk("pc_source", {62'd0, pc_source}, {62'd0, e_src});
        chk("pc_write", {63'd0, pc_write}, {63'd0, e_pw});
        chk("misalign", {63'd0, misalign}, {63'd0, e_mis});
        chk("flush", {63'd0, flush}, {63'd0, m_flush});
        chk("redir_cnt", {48'd0, redir_cnt}, 64'(m_cnt));
        chk("redir_cnt_w2", {62'd0, b_redir_cnt}, 64'((m_cnt > 3) ? 3 : m_cnt));
        chk("jal", {32'd0, jal}, {32'd0, e_jal});
        chk("branch", {32'd0, branch}, {32'd0, e_br});
        chk("jalr", {32'd0, jalr}, {32'd0, e_jalr});
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 3'd0; ex_pc = 32'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0;
        ex_imm_b = 32'd0; ex_imm_j = 32'd0; ex_imm_i = 32'd0;
    endtask

    task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm);
        set_idle(); ex_valid = 1; ex_is_jal = 1; ex_pc = pc; ex_imm_j = imm;
    endtask

    // Assert reset mid-cycle, check quiet outputs, release at the next negedge.
    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_pc_source", {62'd0, pc_source}, 64'd0);
        chk("rst_pc_write", {63'd0, pc_write}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        chk("rst_cnt", {48'd0, redir_cnt}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  exp_src;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{3'b000, 32'd5, 32'd5, 2'b10};
        tbl[1] = '{3'b000, 32'd5, 32'd6, 2'b00};
        tbl[2] = '{3'b001, 32'd5, 32'd6, 2'b10};
        tbl[3] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 2'b10};
        tbl[4] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 2'b00};
        tbl[5] = '{3'b101, 32'd1, 32'hFFFF_FFFF, 2'b10};
        tbl[6] = '{3'b111, 32'd1, 32'hFFFF_FFFF, 2'b00};
        tbl[7] = '{3'b010, 32'd0, 32'd0, 2'b00};
        tbl[8] = '{3'b011, 32'd7, 32'd3, 2'b00};

        rst_n = 0; fetch_ready = 1; set_idle(); model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        cycle();

        // BEQ taken with fetch ready: zero-latency redirect, flush next cycle
        set_idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
        ex_rs1 = 32'd5; ex_rs2 = 32'd5; ex_pc = 32'h100; ex_imm_b = 32'h20;
        #1;
        chk("t1_src", {62'd0, pc_source}, 64'h2);
        chk("t1_branch", {32'd0, branch}, 64'h120);
        chk("t1_pcw", {63'd0, pc_write}, 64'd1);
        cycle();
        set_idle();
        #1;
        chk("t1_flush", {63'd0, flush}, 64'd1);
        chk("t1_cnt", {48'd0, redir_cnt}, 64'd1);
        cycle();

        // table of branch conditions
        for (int i = 0; i < 9; i++) begin
            set_idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = tbl[i].f3;
            ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2; ex_pc = 32'h100; ex_imm_b = 32'h20;
            #1 chk($sformatf("tbl%0d_src", i), {62'd0, pc_source}, {62'd0, tbl[i].exp_src});
            cycle();
        end
        set_idle(); cycle();

        // misaligned JALR: pulse, no redirect, no count
        set_idle(); ex_valid = 1; ex_is_jalr = 1; ex_rs1 = 32'h203; ex_imm_i = 32'd0;
        #1;
        chk("t3_jalr", {32'd0, jalr}, 64'h202);
        chk("t3_mis", {63'd0, misalign}, 64'd1);
        chk("t3_src", {62'd0, pc_source}, 64'd0);
        cycle();
        set_idle(); cycle();

        // JAL stalled three cycles, EX inputs changing meanwhile, then replayed
        fetch_ready = 0; set_jal(32'h40, 32'h80);
        cycle();
        for (int i = 0; i < 2; i++) begin
            set_jal(32'h1000 + 32'(i) * 32'h10, 32'h4);
            #1 chk("t4_pcw_pend", {63'd0, pc_write}, 64'd0);
            cycle();
        end
        fetch_ready = 1; set_idle();
        #1;
        chk("t4_src", {62'd0, pc_source}, 64'h3);
        chk("t4_jal", {32'd0, jal}, 64'hC0);
        cycle();
        #1 chk("t4_flush", {63'd0, flush}, 64'd1);
        cycle();

        // reset during PEND discards the redirect
        fetch_ready = 0; set_jal(32'h40, 32'h80);
        cycle();
        do_reset();
        fetch_ready = 1; set_idle();
        #1;
        chk("t5_src", {62'd0, pc_source}, 64'd0);
        chk("t5_pcw", {63'd0, pc_write}, 64'd1);
        cycle();
        #1 chk("t5_flush", {63'd0, flush}, 64'd0);
        cycle();

        // five taken jumps: 2-bit counter saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_jal(32'h0, 32'h8);
            cycle();
        end
        set_idle();
        #1;
        chk("t6_cnt_w2", {62'd0, b_redir_cnt}, 64'd3);
        chk("t6_cnt_w16", {48'd0, redir_cnt}, 64'd5);
        cycle();
        cycle();
        #1 chk("t6_cnt_hold", {62'd0, b_redir_cnt}, 64'd3);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            fetch_ready  = ($urandom_range(0, 1) == 1);
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_is_jal    = ($urandom_range(0, 5) == 0);
            ex_is_jalr   = ($urandom_range(0, 4) == 0);
            ex_is_branch = ($urandom_range(0, 1) == 1);
            ex_funct3    = 3'($urandom_range(0, 7));
            ex_pc        = $urandom & 32'hFFFF_FFFC;
            ex_imm_b     = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            ex_imm_j     = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            ex_imm_i     = $urandom;
            ex_rs1       = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            ex_rs2       = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
